signed_divider_shift_sub: RTL and testbench

- Sequential signed integer divider; the inverse of the team's shift-add signed multiplier.
- Uses restoring shift-subtract on operand magnitudes, then applies signs.
- Semantics: truncation toward zero; the remainder takes the dividend's sign.
- Sits beside the multiplier in the lab datapath and uses the same CLK/RESET/START/DONE handshake style.

---
 rtl/signed_divider_shift_sub_if.sv | 26 ++
 rtl/signed_divider_shift_sub.sv | 157 +++++++++++++++
 tb/tb_signed_divider_shift_sub.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/signed_divider_shift_sub_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The bench drives the master side and the divider implements the slave side.
interface signed_divider_shift_sub_if #(
    parameter int N = 4
);
    logic                START;
    logic signed [N-1:0] DIVIDEND;
    logic signed [N-1:0] DIVISOR;
    logic                BUSY;
    logic                DONE;
    logic signed [N-1:0] QUOTIENT;
    logic signed [N-1:0] REMAINDER;
    logic                DIV_BY_ZERO;
    logic                OVERFLOW;
    logic [1:0]          STATE;

    modport master (
        output START, DIVIDEND, DIVISOR,
        input  BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO, OVERFLOW, STATE
    );

    modport slave (
        input  START, DIVIDEND, DIVISOR,
        output BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO, OVERFLOW, STATE
    );
endinterface

// File: rtl/signed_divider_shift_sub.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, then signs applied.
// Truncates toward zero; the remainder follows the dividend's sign. Latency is N+2 edges.
module signed_divider_shift_sub #(
    parameter int N = 4
) (
    input logic                     CLK,
    input logic                     RESET,
    signed_divider_shift_sub_if.slave div_if
);

    localparam int               CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]     MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        SIGN = 2'd2,
        HOLD = 2'd3
    } state_e;

    function automatic logic [N-1:0] negate(input logic [N-1:0] v);
        return ~v + ONE_N;
    endfunction

    // The most-negative value maps to 2^(N-1), which still fits in N unsigned bits.
    function automatic logic [N-1:0] magnitude(input logic signed [N-1:0] v);
        return v[N-1] ? negate(v) : v;
    endfunction

    state_e state_q, state_d;
    logic   accept;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;
    logic                ovf_q, ovf_d;
    logic signed [N-1:0] quot_q, quot_d;
    logic signed [N-1:0] rem_q, rem_d;

    logic                sd_q, sd_d;
    logic                sv_q, sv_d;
    logic signed [N-1:0] dvd_q, dvd_d;
    logic [N-1:0]        magv_q, magv_d;
    logic [N-1:0]        p_q, p_d;
    logic [N-1:0]        qm_q, qm_d;

    logic [N:0]          shifted;
    logic [N:0]          trial;

    assign accept = div_if.START && ((state_q == IDLE) || (state_q == HOLD));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HOLD: if (accept) state_d = ITER;
            ITER:       if (cnt_q == LAST_CNT) state_d = SIGN;
            SIGN:       state_d = HOLD;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        div_if.BUSY        = (state_q == ITER) || (state_q == SIGN);
        div_if.DONE        = done_q;
        div_if.QUOTIENT    = quot_q;
        div_if.REMAINDER   = rem_q;
        div_if.DIV_BY_ZERO = dbz_q;
        div_if.OVERFLOW    = ovf_q;
        div_if.STATE       = state_q;
    end

    // Remainder after a successful subtract is below the divisor, so P needs only N stored bits.
    always_comb begin
        shifted = {p_q, qm_q[N-1]};
        trial   = shifted - {1'b0, magv_q};

        cnt_d  = cnt_q;
        done_d = done_q;
        dbz_d  = dbz_q;
        ovf_d  = ovf_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        sd_d   = sd_q;
        sv_d   = sv_q;
        dvd_d  = dvd_q;
        magv_d = magv_q;
        p_d    = p_q;
        qm_d   = qm_q;

        if (accept) begin
            sd_d   = div_if.DIVIDEND[N-1];
            sv_d   = div_if.DIVISOR[N-1];
            dvd_d  = div_if.DIVIDEND;
            magv_d = magnitude(div_if.DIVISOR);
            p_d    = '0;
            qm_d   = magnitude(div_if.DIVIDEND);
            cnt_d  = '0;
            done_d = 1'b0;
            dbz_d  = 1'b0;
            ovf_d  = 1'b0;
        end else if (state_q == ITER) begin
            p_d   = trial[N] ? shifted[N-1:0] : trial[N-1:0];
            qm_d  = {qm_q[N-2:0], ~trial[N]};
            cnt_d = cnt_q + CNT_W'(1);
        end else if (state_q == SIGN) begin
            done_d = 1'b1;
            if (magv_q == '0) begin
                dbz_d  = 1'b1;
                quot_d = '1;
                rem_d  = dvd_q;
            end else begin
                quot_d = (sd_q ^ sv_q) ? negate(qm_q) : qm_q;
                rem_d  = sd_q ? negate(p_q) : p_q;
                ovf_d  = ($unsigned(dvd_q) == MOST_NEG) && sv_q && (magv_q == ONE_N);
            end
        end
    end

    // Control and visible results are reset; operand/working registers are not.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
            ovf_q  <= ovf_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
        end
    end

    always_ff @(posedge CLK) begin
        sd_q   <= sd_d;
        sv_q   <= sv_d;
        dvd_q  <= dvd_d;
        magv_q <= magv_d;
        p_q    <= p_d;
        qm_q   <= qm_d;
    end

endmodule

// File: tb/tb_signed_divider_shift_sub.sv
// Bench for the signed divider: directed cases, protocol checks, exhaustive and random
// operands compared with an integer-arithmetic reference.
module tb_signed_divider_shift_sub;

    localparam int N    = 4;
    localparam int MINV = -(1 << (N - 1));
    localparam int MAXV = (1 << (N - 1)) - 1;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    signed_divider_shift_sub_if #(.N(N)) bus ();

    signed_divider_shift_sub #(.N(N)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .div_if (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wrapn(input int x);
        logic signed [N-1:0] t;
        t = x[N-1:0];
        return int'(t);
    endfunction

    function automatic int absi(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference: native integer division truncates toward zero, remainder takes dividend sign.
    function automatic void ref_div(input int a, input int b, output int q, output int r,
                                    output int dbz, output int ovf);
        dbz = 0;
        ovf = 0;
        if (b == 0) begin
            dbz = 1;
            q   = -1;
            r   = a;
        end else begin
            q   = wrapn(a / b);
            r   = a % b;
            ovf = (a == MINV && b == -1) ? 1 : 0;
        end
    endfunction

    // Called at the falling edge right after the accepting edge.
    task automatic wait_done(output int edges, output int busy);
        edges = 0;
        busy  = 0;
        while (!bus.DONE && edges < 20) begin
            if (bus.BUSY) busy++;
            @(posedge CLK);
            edges++;
            @(negedge CLK);
        end
    endtask

    task automatic run_div(input int a, input int b, input string tag);
        int q, r, dbz, ovf, edges, busy, qo, ro, inv;
        ref_div(a, b, q, r, dbz, ovf);
        @(negedge CLK);
        bus.START    = 1'b1;
        bus.DIVIDEND = a[N-1:0];
        bus.DIVISOR  = b[N-1:0];
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
        wait_done(edges, busy);
        qo = int'(bus.QUOTIENT);
        ro = int'(bus.REMAINDER);
        check({tag, ".lat"}, edges, N + 1);
        check({tag, ".busy"}, busy, N + 1);
        check({tag, ".q"}, qo, q);
        check({tag, ".r"}, ro, r);
        check({tag, ".dbz"}, int'(bus.DIV_BY_ZERO), dbz);
        check({tag, ".ovf"}, int'(bus.OVERFLOW), ovf);
        if (dbz == 0 && ovf == 0) begin
            inv = ((a == qo * b + ro) && (absi(ro) < absi(b)) &&
                   (ro == 0 || ((ro < 0) == (a < 0)))) ? 1 : 0;
            check({tag, ".inv"}, inv, 1);
        end
    endtask

    initial begin
        int edges, busy, saw_done;
        logic [31:0] rnd;
        logic signed [N-1:0] ra, rb;

        RESET        = 1'b1;
        bus.START    = 1'b0;
        bus.DIVIDEND = '0;
        bus.DIVISOR  = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst.done", int'(bus.DONE), 0);
        check("rst.busy", int'(bus.BUSY), 0);
        check("rst.q", int'(bus.QUOTIENT), 0);
        check("rst.r", int'(bus.REMAINDER), 0);
        check("rst.dbz", int'(bus.DIV_BY_ZERO), 0);
        check("rst.ovf", int'(bus.OVERFLOW), 0);
        check("rst.state", int'(bus.STATE), 0);
        RESET = 1'b0;

        run_div(7, 2, "7/2");
        check("7/2.qconst", int'(bus.QUOTIENT), 3);
        run_div(-7, 2, "-7/2");
        run_div(7, -2, "7/-2");
        run_div(-8, 3, "-8/3");
        run_div(-8, -8, "-8/-8");
        run_div(5, 0, "5/0");
        check("5/0.qconst", int'(bus.QUOTIENT), -1);
        run_div(-8, -1, "-8/-1");
        check("-8/-1.qconst", int'(bus.QUOTIENT), -8);

        // START pulsed mid-iteration with different operands must be ignored.
        @(negedge CLK);
        bus.START = 1'b1; bus.DIVIDEND = 4'sd7; bus.DIVISOR = 4'sd2;
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b1; bus.DIVIDEND = 4'sd3; bus.DIVISOR = 4'sd1;
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
        wait_done(edges, busy);
        check("ign.done", int'(bus.DONE), 1);
        check("ign.q", int'(bus.QUOTIENT), 3);
        check("ign.r", int'(bus.REMAINDER), 1);

        // START held high through HOLD restarts immediately.
        @(negedge CLK);
        bus.START = 1'b1; bus.DIVIDEND = 4'sd7; bus.DIVISOR = 4'sd2;
        @(posedge CLK);
        @(negedge CLK);
        wait_done(edges, busy);
        check("held.lat", edges, N + 1);
        check("held.q1", int'(bus.QUOTIENT), 3);
        bus.DIVIDEND = 4'sd6; bus.DIVISOR = 4'sd3;
        @(posedge CLK);
        @(negedge CLK);
        check("held.done_drop", int'(bus.DONE), 0);
        check("held.state", int'(bus.STATE), 1);
        check("held.q_keep", int'(bus.QUOTIENT), 3);
        bus.START = 1'b0;
        wait_done(edges, busy);
        check("held.q2", int'(bus.QUOTIENT), 2);
        check("held.r2", int'(bus.REMAINDER), 0);

        // RESET sampled on the second iteration edge aborts the operation.
        @(negedge CLK);
        bus.START = 1'b1; bus.DIVIDEND = 4'sd7; bus.DIVISOR = 4'sd2;
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        check("abort.state", int'(bus.STATE), 0);
        check("abort.busy", int'(bus.BUSY), 0);
        check("abort.done", int'(bus.DONE), 0);
        check("abort.q", int'(bus.QUOTIENT), 0);
        check("abort.r", int'(bus.REMAINDER), 0);
        check("abort.dbz", int'(bus.DIV_BY_ZERO), 0);
        check("abort.ovf", int'(bus.OVERFLOW), 0);
        saw_done = 0;
        repeat (8) begin
            @(negedge CLK);
            if (bus.DONE) saw_done = 1;
        end
        check("abort.no_done", saw_done, 0);
        run_div(6, 3, "post_rst6/3");
        check("post_rst.qconst", int'(bus.QUOTIENT), 2);

        for (int a = MINV; a <= MAXV; a++) begin
            for (int b = MINV; b <= MAXV; b++) begin
                run_div(a, b, $sformatf("sw%0d/%0d", a, b));
            end
        end

        for (int i = 0; i < 100; i++) begin
            rnd = $urandom();
            ra  = rnd[N-1:0];
            rb  = rnd[2*N-1:N];
            run_div(int'(ra), int'(rb), $sformatf("rnd%0d/%0d", ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
